score_display: RTL and testbench
================================

// Module: score_display
//
// PURPOSE
// Multi-digit decimal display driver for the DE1-SoC HEX displays, which are driven directly and not multiplexed.
// Accepts a binary score and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
// Drives NUM_DIGITS active-low 7-segment digits with leading-zero blanking, overflow indication and optional blinking.
// Sits between the game score counters and the top-level HEXn pins.
//
// PARAMETERS
// NUM_DIGITS     2           number of decimal digits driven (1..6)
// BIN_W          7           width of the binary input value
// BLINK_DIV      25_000_000  clocks per blink half-period (0.5 s at 50 MHz); must be >= 1
// LZ_BLANK       1           1 = blank leading zeros, 0 = show all digits
//
// PORTS
// clk       in   1               system clock; all logic on rising edge
// reset     in   1               synchronous, active-high reset
// value     in   BIN_W           binary value to display
// load      in   1               start-conversion strobe; sampled only when busy=0
// blink_en  in   1               1 = blank all digits during the off phase of the blink counter
// busy      out  1               conversion in progress
// done      out  1               one-cycle pulse; display register updated on the same edge
// overflow  out  1               registered; 1 = last loaded value > 10**NUM_DIGITS-1
// hex       out  7*NUM_DIGITS    segments, active-low, {g..a} per digit; digit 0 = hex[6:0] = least significant
//
// BEHAVIOUR
// - Reset values:
//   - busy=0, done=0, overflow=0.
//   - Display register = 0, so hex shows "0" on digit 0 and blank (7'h7F) elsewhere; with LZ_BLANK=0 it shows all "0".
//   - Blink counter=0, blink phase=visible.
// - Reset during a conversion aborts it; the next cycle is busy=0 and the display is at its reset value.
// - Accept (load=1 && busy=0, edge E):
//   - capture value into the shift register; clear the BCD accumulator; bit count=0; busy=1.
//   - overflow_next = (value >= 10**NUM_DIGITS); the comparison constant is a localparam.
// - load while busy=1 is ignored. It is not queued and has no effect on the conversion in progress.
// - Edges E+1..E+BIN_W perform one iteration each:
//   - every BCD nibble >= 5 gets +3;
//   - then {bcd,shift} is shifted left 1.
// - At edge E+BIN_W:
//   - the display register <= final BCD; overflow <= overflow_next; busy <= 0; done <= 1 for exactly one cycle.
//   - Latency from load edge to new hex value = BIN_W cycles.
//   - load may be accepted again on the edge following the done edge.
// - BCD accumulator width: 4*NUM_DIGITS bits. Carries beyond it are discarded; overflow is flagged separately.
// - Output decode (combinational from registers):
//   - overflow=1: every digit = dash 7'b0111111.
//   - else digit k = seg(bcd[k]). With LZ_BLANK=1, digit k (k>0) is blank when it and all higher digits are 0.
//   - Digit 0 is never blanked by leading-zero logic.
//   - Segment codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, active-low); codes 10..15 = blank 7F.
// - Blink:
//   - A free-running counter counts 0..BLINK_DIV-1 and wraps. The phase toggles on each wrap.
//   - It runs regardless of blink_en.
//   - When blink_en=1 and phase=off, hex = all 7'h7F. Blinking has no effect on the conversion or its state.
// - Sequential state: IDLE (busy=0) -> CONV on accept; CONV -> IDLE after BIN_W iterations; any state -> IDLE on reset.
//
// STRUCTURE
// - Shared package/include: SEG_BLANK=7'h7F, SEG_DASH=7'h3F, the 10-entry digit segment table, and a clog2 helper for the counter widths.
// - One sub-module: digit_to_seg, a combinational 4-bit BCD to 7-segment active-low decoder with blank for 10..15.
//   It is instantiated NUM_DIGITS times in a generate loop.
// - The double-dabble engine, LZ mask, overflow compare and blink counter are inline in score_display.
//
// TESTING (NUM_DIGITS=2, BIN_W=7, BLINK_DIV=4, LZ_BLANK=1)
// 1. Assert reset 2 cycles -> busy=0, done=0, overflow=0, hex={7F,40}.
// 2. load with value=42 at edge E -> busy=1 for 7 cycles; at edge E+7: done=1 for one cycle and hex={19,24}.
// 3. value=7 -> hex={7F,78}. value=0 -> hex={7F,40}. value=90 -> hex={10,40}.
// 4. value=100 -> overflow=1, hex={3F,3F}. Then value=99 -> overflow=0, hex={10,10}.
// 5. load 42, then load 13 at E+3 -> 13 is ignored and the result is {19,24}. Reset at E+4 -> busy=0 next cycle, hex={7F,40}, no done pulse.
// 6. blink_en=1 with 42 displayed -> hex alternates 4 cycles {19,24} and 4 cycles {7F,7F}. Clear blink_en -> steady {19,24}.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared constants and helpers for the score display driver: segment codes,
// the decimal digit segment table, the conversion state type and a width helper.
package score_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_t;

  // Bits needed to hold 0..n-1; never returns less than 1 so counters stay legal
  function automatic int clog2(input int n);
    int w;
    int v;
    w = 0;
    v = n - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // BCD nibble to segments; non-decimal codes 10..15 show nothing
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_TABLE[0];
      4'd1:    s = SEG_TABLE[1];
      4'd2:    s = SEG_TABLE[2];
      4'd3:    s = SEG_TABLE[3];
      4'd4:    s = SEG_TABLE[4];
      4'd5:    s = SEG_TABLE[5];
      4'd6:    s = SEG_TABLE[6];
      4'd7:    s = SEG_TABLE[7];
      4'd8:    s = SEG_TABLE[8];
      4'd9:    s = SEG_TABLE[9];
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_display_digit_to_seg.sv
// Combinational BCD digit to active-low 7-segment decoder; 10..15 decode to blank.
module digit_to_seg
  import score_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = seg_of(i_bcd);

endmodule

// File: rtl/score_display.sv
// Score display driver: serial double-dabble binary-to-BCD conversion (one bit
// per clock), leading-zero blanking, overflow dashes and an optional blink.
module score_display
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_W      = 7,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int LZ_BLANK   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BIN_W-1:0]        value,
  input  logic                    load,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int BCD_W    = 4 * NUM_DIGITS;
  localparam int BITCNT_W = clog2(BIN_W);
  localparam int BLINK_W  = clog2(BLINK_DIV);
  // Smallest value that no longer fits in NUM_DIGITS decimal digits
  localparam longint unsigned OVF_LIMIT = 64'(10 ** NUM_DIGITS);

  conv_state_t          r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic                 r_ovf_next;
  logic [BIN_W-1:0]     r_shift;
  logic [BCD_W-1:0]     r_bcd;
  logic [BCD_W-1:0]     r_disp;
  logic [BITCNT_W-1:0]  r_bit_cnt;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_blink_off;

  logic [BCD_W-1:0]     w_bcd_adj;
  logic [BCD_W-1:0]     w_bcd_step;
  logic                 w_value_ovf;
  logic                 w_last_bit;
  logic                 w_hide_all;

  genvar gi;

  // Add-3 correction on every nibble that would exceed 9 after doubling
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                    (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
    end
  endgenerate

  // One shift of {bcd,shift}: MSB of the binary operand enters the BCD LSB.
  // Carries out of the top nibble are dropped; overflow is tracked separately.
  assign w_bcd_step  = {w_bcd_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_value_ovf = (64'(value) >= OVF_LIMIT);
  assign w_last_bit  = (r_bit_cnt == BITCNT_W'(BIN_W - 1));

  // Conversion FSM: accept in IDLE, iterate BIN_W times in CONV, publish on last
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_ovf_next <= 1'b0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_disp     <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_shift    <= value;
            r_bcd      <= '0;
            r_bit_cnt  <= '0;
            r_ovf_next <= w_value_ovf;
            r_busy     <= 1'b1;
            r_state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bcd   <= w_bcd_step;
          r_shift <= r_shift << 1;
          if (w_last_bit) begin
            r_disp     <= w_bcd_step;
            r_overflow <= r_ovf_next;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + BITCNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running blink timebase; phase flips each time the counter wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign w_hide_all = blink_en && r_blink_off;

  // Per-digit decode with priority: blink-off, overflow dash, leading-zero blank
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      // Digit 0 always shows something so a zero score reads "0"
      localparam bit LZ_ACTIVE = (LZ_BLANK != 0) && (gi > 0);
      logic [6:0] w_dec_seg;
      logic       w_upper_zero;

      digit_to_seg u_dec (
        .i_bcd (r_disp[4*gi +: 4]),
        .o_seg (w_dec_seg)
      );

      assign w_upper_zero = (r_disp[BCD_W-1:4*gi] == '0);

      assign hex[7*gi +: 7] = w_hide_all                  ? SEG_BLANK :
                              r_overflow                  ? SEG_DASH  :
                              (LZ_ACTIVE && w_upper_zero) ? SEG_BLANK :
                                                            w_dec_seg;
    end
  endgenerate

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display (2 digits, 7-bit input, blink every 4
// clocks). Expected results are queued when a load is driven and compared when
// the DUT pulses done.
module tb_score_display;

  localparam int ND = 2;
  localparam int BW = 7;
  localparam int BD = 4;

  logic          clk;
  logic          reset;
  logic [BW-1:0] value;
  logic          load;
  logic          blink_en;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [7*ND-1:0] hex;

  typedef struct {
    logic [13:0] hex;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   m_cnt;
  bit   m_off;

  score_display #(
    .NUM_DIGITS (ND),
    .BIN_W      (BW),
    .BLINK_DIV  (BD),
    .LZ_BLANK   (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .blink_en (blink_en),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hex      (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp and an independent model of the blink phase
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_cnt = 0;
      m_off = 1'b0;
    end else if (m_cnt == BD - 1) begin
      m_cnt = 0;
      m_off = ~m_off;
    end else begin
      m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
    else
      n_pass++;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending load
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hex", 64'(hex), 64'(e.hex));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic conv(input int v, input logic [13:0] eh, input logic eo, input bit inject);
    exp_t e;
    int   n;
    value = 7'(v);
    load  = 1'b1;
    @(posedge clk); #1;
    load     = 1'b0;
    e.hex    = eh;
    e.ovf    = eo;
    e.due    = cyc + BW;
    sb.push_back(e);
    n = 0;
    while (busy && n < 20) begin
      if (inject && n == 2) begin
        value = 7'd13;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      n++;
      @(posedge clk); #1;
    end
    load = 1'b0;
    chk("busy_cycles", 64'(n), 64'(BW));
    @(posedge clk); #1;
    $display("conv value=%0d inject=%0d hex=%h overflow=%0b", v, inject, hex, overflow);
  endtask

  initial begin
    int offs;
    logic [13:0] want;
    cyc      = 0;
    n_checks = 0;
    n_pass   = 0;
    m_cnt    = 0;
    m_off    = 1'b0;
    reset    = 1'b1;
    value    = '0;
    load     = 1'b0;
    blink_en = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_hex", 64'(hex), 64'({7'h7F, 7'h40}));
    $display("reset hex=%h", hex);

    // Main conversions, including overflow boundary 99/100
    conv(42,  {7'h19, 7'h24}, 1'b0, 1'b0);
    conv(7,   {7'h7F, 7'h78}, 1'b0, 1'b0);
    conv(0,   {7'h7F, 7'h40}, 1'b0, 1'b0);
    conv(90,  {7'h10, 7'h40}, 1'b0, 1'b0);
    conv(10,  {7'h79, 7'h40}, 1'b0, 1'b0);
    conv(100, {7'h3F, 7'h3F}, 1'b1, 1'b0);
    conv(99,  {7'h10, 7'h10}, 1'b0, 1'b0);
    conv(127, {7'h3F, 7'h3F}, 1'b1, 1'b0);
    // Load of 13 during busy must be ignored
    conv(42,  {7'h19, 7'h24}, 1'b0, 1'b1);

    // Blink: model phase decides between digits and all blank
    blink_en = 1'b1;
    offs = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      want = m_off ? {7'h7F, 7'h7F} : {7'h19, 7'h24};
      if (m_off) offs++;
      chk("blink_hex", 64'(hex), 64'(want));
    end
    chk("blink_off_cycles", 64'(offs), 64'd8);
    $display("blink off_cycles=%0d of 16", offs);
    blink_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("steady_hex", 64'(hex), 64'({7'h19, 7'h24}));
    end

    // Reset at E+4 aborts the conversion; no done may follow
    value = 7'd99;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hex", 64'(hex), 64'({7'h7F, 7'h40}));
    repeat (10) @(posedge clk);
    #2;
    chk("abort_idle_busy", 64'(busy), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("abort hex=%h busy=%0b", hex, busy);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
